// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM states for the ALU sweep driver.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_NOTA = 3'b100;
    localparam logic [2:0] OP_NOTB = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_XNOR = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        EMIT,
        DONE
    } state_t;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational reference of the 4-bit ALU; all results wrap modulo 2^W.
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic [W-1:0] res
);

    // Opcode decode to the expected result
    always_comb begin
        res = '0;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_NOTA: res = ~a;
            OP_NOTB: res = ~b;
            OP_XOR:  res = a ^ b;
            OP_XNOR: res = ~(a ^ b);
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_sweep_driver.sv
// Sweeps one latched operand pair through all eight ALU opcodes, checks each
// result against the reference model and streams it out on valid/ready.
//
// state   | meaning
// IDLE    | waiting for start; operands retained, opcode parked at 000
// SETTLE  | ALU inputs held while the settle counter runs down
// CAPTURE | sample alu_res, compare with reference, raise res_valid
// EMIT    | hold the beat until res_ready, then advance or finish
// DONE    | one-cycle done pulse, back to IDLE
module alu_sweep_driver
    import alu_pkg::*;
#(
    parameter int W          = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_op,
    input  logic [W-1:0] alu_res,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic [2:0]   res_op,
    output logic         res_err,
    output logic         busy,
    output logic         done,
    output logic [3:0]   mismatch_cnt
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    state_t       state_q;
    state_t       state_d;
    logic [3:0]   settle_cnt;
    logic [W-1:0] ref_res;
    logic         err_now;
    logic         accept;
    logic         capture;
    logic         handshake;

    alu_ref_model #(.W(W)) u_ref (
        .a   (alu_a),
        .b   (alu_b),
        .op  (alu_op),
        .res (ref_res)
    );

    assign err_now = (alu_res != ref_res);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-cycle action strobes
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        capture   = 1'b0;
        handshake = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == 4'd0) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                capture = 1'b1;
                state_d = EMIT;
            end
            EMIT: begin
                if (res_valid && res_ready) begin
                    handshake = 1'b1;
                    state_d   = (alu_op == OP_XNOR) ? DONE : SETTLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: operand latch, settle timer, result capture and beat handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= OP_ADD;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_op       <= 3'b000;
            res_err      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mismatch_cnt <= 4'd0;
            settle_cnt   <= 4'd0;
        end else begin
            done <= (state_d == DONE);
            if (accept) begin
                alu_a        <= a_in;
                alu_b        <= b_in;
                alu_op       <= OP_ADD;
                mismatch_cnt <= 4'd0;
                busy         <= 1'b1;
                settle_cnt   <= SETTLE_LOAD;
            end
            if (state_q == SETTLE && settle_cnt != 4'd0) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
            if (capture) begin
                res_data  <= alu_res;
                res_op    <= alu_op;
                res_err   <= err_now;
                res_valid <= 1'b1;
                if (err_now) begin
                    mismatch_cnt <= mismatch_cnt + 4'd1;
                end
            end
            if (handshake) begin
                res_valid <= 1'b0;
                if (alu_op != OP_XNOR) begin
                    alu_op     <= alu_op + 3'd1;
                    settle_cnt <= SETTLE_LOAD;
                end else begin
                    alu_op <= OP_ADD;
                    busy   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_sweep_driver.sv
// Directed bench for alu_sweep_driver with a modelled ALU and fault injection.
module tb_alu_sweep_driver;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a_in, b_in;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_res;
    logic [3:0] model_res;
    logic       res_valid, res_ready;
    logic [3:0] res_data;
    logic [2:0] res_op;
    logic       res_err, busy, done;
    logic [3:0] mismatch_cnt;
    int         fault_op = -1;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    alu_sweep_driver #(.W(4), .SETTLE_CYC(1)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_op(res_op), .res_err(res_err), .busy(busy), .done(done),
        .mismatch_cnt(mismatch_cnt)
    );

    alu_ref_model #(.W(4)) u_alu (.a(alu_a), .b(alu_b), .op(alu_op), .res(model_res));

    always_comb begin
        alu_res = model_res;
        if (fault_op >= 0 && int'(alu_op) == fault_op) alu_res = 4'b0000;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; res_ready = 1'b1;
        tick(); tick();
        total++;
        if ({alu_a, alu_b, alu_op, res_valid, res_data, res_op, res_err, busy, done, mismatch_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got a=%h b=%h op=%h v=%b d=%h rop=%h err=%b busy=%b done=%b mm=%h, want all 0",
                     alu_a, alu_b, alu_op, res_valid, res_data, res_op, res_err, busy, done, mismatch_cnt);
        end
        rst = 1'b0;
        tick();
    endtask

    // exp_d holds the expected res_data for opcode k in nibble k
    task automatic do_sweep(input string name, input logic [3:0] a, input logic [3:0] b,
                            input logic [31:0] exp_d, input logic [7:0] exp_err,
                            input int stall_op, input bit hold_start, input logic [3:0] exp_mm);
        int cyc = 1;
        int beats = 0;
        int stall = 0;
        bit got_done = 0;
        int exp_done_cyc = (stall_op >= 0) ? 30 : 25;
        a_in = a; b_in = b; start = 1'b1; res_ready = 1'b1;
        tick();
        if (!hold_start) start = 1'b0;
        while (cyc <= 80 && !got_done) begin
            if (cyc == 6) begin a_in = ~a; b_in = ~b; end
            res_ready = 1'b1;
            if (res_valid && int'(res_op) == stall_op && stall < 5) begin
                res_ready = 1'b0;
                stall++;
                total++;
                if (res_data !== exp_d[4*stall_op +: 4] || alu_op !== 3'(stall_op)) begin
                    bad++;
                    $display("FAIL %s stall_hold: got data=%h alu_op=%h, want data=%h alu_op=%0d",
                             name, res_data, alu_op, exp_d[4*stall_op +: 4], stall_op);
                end
            end
            if (res_valid && res_ready) begin
                total++;
                if (beats > 7 || res_op !== 3'(beats) || res_data !== exp_d[4*beats +: 4]
                    || res_err !== exp_err[beats]) begin
                    bad++;
                    $display("FAIL %s beat%0d: got op=%h data=%h err=%b, want op=%0d data=%h err=%b",
                             name, beats, res_op, res_data, res_err, beats,
                             exp_d[4*(beats & 7) +: 4], exp_err[beats & 7]);
                end
                if (beats == 0) begin
                    total++;
                    if (cyc != 3) begin
                        bad++;
                        $display("FAIL %s first_valid_cycle: got %0d, want 3", name, cyc);
                    end
                end
                beats++;
            end
            if (done) begin
                got_done = 1;
                start = 1'b0;
                total++;
                if (cyc != exp_done_cyc || beats != 8 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL %s done: got cycle=%0d beats=%0d busy=%b, want cycle=%0d beats=8 busy=0",
                             name, cyc, beats, busy, exp_done_cyc);
                end
            end else begin
                tick();
                cyc++;
            end
        end
        start = 1'b0;
        if (!got_done) begin
            total++; bad++;
            $display("FAIL %s timeout: got no done after %0d cycles, want done", name, cyc);
        end
        tick(); tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || mismatch_cnt !== exp_mm || alu_a !== a || alu_b !== b
            || alu_op !== 3'b000 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_after: got done=%b busy=%b mm=%h a=%h b=%h op=%h v=%b, want 0 0 %h %h %h 0 0",
                     name, done, busy, mismatch_cnt, alu_a, alu_b, alu_op, res_valid, exp_mm, a, b);
        end
    endtask

    task automatic test_basic();
        do_sweep("basic", 4'b0100, 4'b0011, 32'h8_7_C_B_7_0_1_7, 8'h00, -1, 0, 4'd0);
    endtask

    task automatic test_wrap();
        do_sweep("wrap", 4'b1111, 4'b0001, 32'h1_E_E_0_F_1_E_0, 8'h00, -1, 0, 4'd0);
    endtask

    task automatic test_backpressure();
        do_sweep("backpressure", 4'b0100, 4'b0011, 32'h8_7_C_B_7_0_1_7, 8'h00, 3, 0, 4'd0);
    endtask

    task automatic test_fault();
        fault_op = 6;
        do_sweep("fault", 4'b0100, 4'b0011, 32'h8_0_C_B_7_0_1_7, 8'h40, -1, 0, 4'd1);
        fault_op = -1;
    endtask

    task automatic test_start_held();
        do_sweep("start_held", 4'b0100, 4'b0011, 32'h8_7_C_B_7_0_1_7, 8'h00, -1, 1, 4'd0);
    endtask

    task automatic test_rst_mid();
        int n = 0;
        fault_op = 1;
        a_in = 4'b0100; b_in = 4'b0011; start = 1'b1; res_ready = 1'b1;
        tick();
        start = 1'b0;
        while (n < 40 && !(alu_op == 3'd4 && !res_valid && busy)) begin
            tick();
            n++;
        end
        total++;
        if (n >= 40) begin
            bad++;
            $display("FAIL rst_mid reach_settle4: got op=%h after %0d cycles, want op=4", alu_op, n);
        end
        total++;
        if (mismatch_cnt !== 4'd1) begin
            bad++;
            $display("FAIL rst_mid pre_mm: got %h, want 1", mismatch_cnt);
        end
        fault_op = -1;
        rst = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || alu_op !== 3'b000 || mismatch_cnt !== 4'd0
            || done !== 1'b0 || alu_a !== 4'd0) begin
            bad++;
            $display("FAIL rst_mid cleared: got busy=%b v=%b op=%h mm=%h done=%b a=%h, want all 0",
                     busy, res_valid, alu_op, mismatch_cnt, done, alu_a);
        end
        rst = 1'b0;
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid no_done: got done=%b busy=%b, want 0 0", done, busy);
        end
        do_sweep("after_rst", 4'b0100, 4'b0011, 32'h8_7_C_B_7_0_1_7, 8'h00, -1, 0, 4'd0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_fault();
        test_start_held();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
